// File: rtl/irq_controller_pkg.sv
// Shared definitions for the memory-mapped interrupt controller: window base,
// register byte offsets and the word-offset decode enum.
package irq_controller_pkg;

    localparam logic [31:0] IrqBase  = 32'h0000_0900;

    localparam logic [4:0]  IrqPend  = 5'h00;
    localparam logic [4:0]  IrqMask  = 5'h04;
    localparam logic [4:0]  IrqEdge  = 5'h08;
    localparam logic [4:0]  IrqStat  = 5'h0C;
    localparam logic [4:0]  IrqSwset = 5'h10;

    // Word offset within the window, i.e. addr[4:2].
    typedef enum logic [2:0] {
        OffPend  = IrqPend[4:2],
        OffMask  = IrqMask[4:2],
        OffEdge  = IrqEdge[4:2],
        OffStat  = IrqStat[4:2],
        OffSwset = IrqSwset[4:2]
    } irq_off_e;

endpackage

// File: rtl/irq_controller_sync_edge.sv
// Per-source synchroniser chain with a one-cycle delayed copy of its output
// for rising-edge detection.
module irq_controller_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], a_i};
            level_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~level_dly_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronises requests, latches them into
// PEND, masks them and drives a registered interrupt vector to the core.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned N_SRC       = 5,
    parameter logic [31:0] BASE_ADDR   = IrqBase,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wd_i,
    input  logic             we_i,
    output logic             sel_o,
    output logic [31:0]      rd_o,
    output logic [N_SRC-1:0] int_o
);

    logic [N_SRC-1:0] level, rise;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] int_q;
    logic [N_SRC-1:0] clr, swset;
    logic             wr_en;
    logic             unused_bits;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_controller_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .a_i    (irq_src_i[i]),
            .level_o(level[i]),
            .rise_o (rise[i])
        );
    end

    assign sel_o       = (addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr_en       = we_i & sel_o;
    assign unused_bits = ^{addr_i[1:0], wd_i[31:N_SRC]};

    always_comb begin
        clr    = '0;
        swset  = '0;
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_en) begin
            case (addr_i[4:2])
                OffPend:  clr    = wd_i[N_SRC-1:0];
                OffMask:  mask_d = wd_i[N_SRC-1:0];
                OffEdge:  edge_d = wd_i[N_SRC-1:0];
                OffSwset: swset  = wd_i[N_SRC-1:0];
                default:  ;
            endcase
        end
        // Set terms are OR'd after the clear so a same-cycle request is never lost.
        pend_d = (edge_q & ((pend_q & ~clr) | rise | swset)) | (~edge_q & level);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '1;
            int_q  <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            int_q  <= pend_q & mask_q;
        end
    end

    assign int_o = int_q;

    always_comb begin
        rd_o = '0;
        if (sel_o) begin
            case (addr_i[4:2])
                OffPend: rd_o[N_SRC-1:0] = pend_q;
                OffMask: rd_o[N_SRC-1:0] = mask_q;
                OffEdge: rd_o[N_SRC-1:0] = edge_q;
                OffStat: rd_o[N_SRC-1:0] = pend_q & mask_q;
                default: rd_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios followed by randomized bus/request traffic, all checked
// against a delay-line reference model of the controller.
module tb_irq_controller;

    localparam int unsigned NS   = 5;
    localparam int unsigned SS   = 2;
    localparam logic [31:0] BASE = 32'h0000_0900;

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] irq_src;
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic          we;
    logic          sel;
    logic [31:0]   rd;
    logic [NS-1:0] int_v;

    irq_controller #(
        .N_SRC      (NS),
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .irq_src_i(irq_src),
        .addr_i   (addr),
        .wd_i     (wd),
        .we_i     (we),
        .sel_o    (sel),
        .rd_o     (rd),
        .int_o    (int_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: s is irq_src as sampled SS edges ago (m_hist[0] = newest sample).
    logic [NS-1:0] m_pend, m_mask, m_edge, m_int;
    logic [NS-1:0] m_hist[$];

    function automatic logic [NS-1:0] m_s(int k);
        return (m_hist.size() > k) ? m_hist[k] : '0;
    endfunction

    function automatic logic [31:0] m_rd(logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0:    r[NS-1:0] = m_pend;
                3'd1:    r[NS-1:0] = m_mask;
                3'd2:    r[NS-1:0] = m_edge;
                3'd3:    r[NS-1:0] = m_pend & m_mask;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic m_reset();
        m_pend = '0;
        m_mask = '0;
        m_edge = '1;
        m_int  = '0;
        m_hist.delete();
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [NS-1:0] s, sd, clr, sw, pn, mn, en, smp;
        logic          hit;
        s   = m_s(SS - 1);
        sd  = m_s(SS);
        hit = we && (addr[31:5] == BASE[31:5]);
        clr = (hit && addr[4:2] == 3'd0) ? wd[NS-1:0] : '0;
        mn  = (hit && addr[4:2] == 3'd1) ? wd[NS-1:0] : m_mask;
        en  = (hit && addr[4:2] == 3'd2) ? wd[NS-1:0] : m_edge;
        sw  = (hit && addr[4:2] == 3'd4) ? wd[NS-1:0] : '0;
        for (int i = 0; i < NS; i++) begin
            if (m_edge[i]) pn[i] = (s[i] && !sd[i]) || sw[i] || (m_pend[i] && !clr[i]);
            else           pn[i] = s[i];
        end
        smp = irq_src;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_reset();
        end else begin
            m_int  = m_pend & m_mask;
            m_pend = pn;
            m_mask = mn;
            m_edge = en;
            m_hist.push_front(smp);
            if (m_hist.size() > SS + 1) void'(m_hist.pop_back());
        end
        check("int_model", 32'(int_v), 32'(m_int));
    endtask

    task automatic wr(logic [4:0] off, logic [31:0] d);
        addr = BASE | 32'(off);
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic rdchk(string tag, logic [4:0] off, logic [31:0] exp);
        addr = BASE | 32'(off);
        #1;
        check(tag, rd, exp);
        check({tag, "_sel"}, 32'(sel), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        irq_src = '0;
        addr    = '0;
        wd      = '0;
        we      = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_int", 32'(int_v), 32'd0);
        rdchk("rst_pend", 5'h00, 32'h0);
        rdchk("rst_edge", 5'h08, 32'h1F);
        #1;
        rst_n = 1'b1;

        // 1: 3-cycle pulse on src 2, INT after edge 4, stays pending.
        wr(5'h04, 32'h1F);
        irq_src = 5'b00100;
        tick(); tick(); tick();
        irq_src = '0;
        check("t1_int_edge3", 32'(int_v), 32'h0);
        tick();
        check("t1_int_edge4", 32'(int_v), 32'h4);
        rdchk("t1_pend", 5'h00, 32'h4);
        tick(); tick(); tick();
        check("t1_int_hold", 32'(int_v), 32'h4);

        // 2: W1C drops INT on the following edge.
        wr(5'h00, 32'h4);
        check("t2_int_store", 32'(int_v), 32'h4);
        tick();
        check("t2_int_clr", 32'(int_v), 32'h0);
        rdchk("t2_pend", 5'h00, 32'h0);

        // 3: clear coinciding with a new rise keeps the request.
        wr(5'h10, 32'h4);
        tick();
        check("t3_int_sw", 32'(int_v), 32'h4);
        irq_src = 5'b00100;
        tick(); tick();
        wr(5'h00, 32'h4);
        rdchk("t3_pend", 5'h00, 32'h4);
        tick();
        check("t3_int", 32'(int_v), 32'h4);
        irq_src = '0;
        tick(); tick(); tick();
        wr(5'h00, 32'h4);
        tick();
        check("t3_int_cleared", 32'(int_v), 32'h0);

        // 4: level mode on src 0.
        wr(5'h08, 32'h1E);
        irq_src = 5'b00001;
        tick(); tick(); tick(); tick();
        check("t4_int_level", 32'(int_v), 32'h1);
        wr(5'h00, 32'h1);
        tick();
        check("t4_w1c_ignored", 32'(int_v), 32'h1);
        irq_src = '0;
        tick(); tick(); tick();
        tick();
        check("t4_int_drop", 32'(int_v), 32'h0);
        wr(5'h08, 32'h1F);

        // 5: software set while masked, then unmask.
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h10);
        rdchk("t5_stat", 5'h0C, 32'h0);
        rdchk("t5_pend", 5'h00, 32'h10);
        rdchk("t5_swset_rd", 5'h10, 32'h0);
        tick();
        check("t5_int_masked", 32'(int_v), 32'h0);
        wr(5'h04, 32'h10);
        tick();
        check("t5_int", 32'(int_v), 32'h10);

        // 6: asynchronous reset mid-cycle with everything pending.
        wr(5'h10, 32'h1F);
        wr(5'h04, 32'h1F);
        tick();
        check("t6_int_pre", 32'(int_v), 32'h1F);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("t6_int_rst", 32'(int_v), 32'h0);
        rdchk("t6_pend", 5'h00, 32'h0);
        rdchk("t6_mask", 5'h04, 32'h0);
        rdchk("t6_off14", 5'h14, 32'h0);
        rdchk("t6_off18", 5'h18, 32'h0);
        rdchk("t6_off1c", 5'h1C, 32'h0);
        addr = 32'h0000_1000;
        #1;
        check("t6_sel_out", 32'(sel), 32'd0);
        check("t6_rd_out", rd, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src = NS'($urandom);
            we   = ($urandom_range(0, 2) == 0);
            wd   = $urandom;
            addr = BASE | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            #1;
            check("rnd_rd", rd, m_rd(addr));
            check("rnd_sel", 32'(sel), 32'(addr[31:5] == BASE[31:5]));
            tick();
        end
        we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
